if_id_pipe_reg: RTL
===================

Name: if_id_pipe_reg

Overview:
- IF/ID pipeline register of the 5-stage MIPS core; sits directly downstream of the fetch stage (PC register + instruction memory).
- Captures fetched instruction, PC and PC+4 each cycle; supports stall (hold), flush (bubble insert) and fetch-address exception tagging.
- Presents sliced instruction fields to the decode stage and hazard unit.

Parameters:
- PC_RESET, 32'h0000_3000, reset/base value of the captured PC
- IM_WORDS, 1024, instruction memory depth in words; defines the legal fetch window
- EXC_ADEL, 5'd4, exception code for a bad fetch address

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold all state this cycle (from hazard unit)
- flush  in  1  replace captured content with a bubble
- f_instr  in  32  instruction fetched this cycle
- f_pc  in  32  PC of f_instr
- f_pc4  in  32  f_pc + 4
- d_instr  out  32  registered instruction (0 = nop)
- d_pc  out  32  registered PC
- d_pc4  out  32  registered PC+4
- d_valid  out  1  1 = real instruction, 0 = bubble
- d_excode  out  5  0 = none, EXC_ADEL = bad fetch address
- d_op, d_funct  out  6 each  instr[31:26], instr[5:0]
- d_rs, d_rt, d_rd, d_shamt  out  5 each  instr[25:21], [20:16], [15:11], [10:6]
- d_imm16  out  16  instr[15:0]
- d_imm26  out  26  instr[25:0]

Behaviour:
- Reset asserted (reset=0), immediate and independent of clk: d_instr=0, d_pc=PC_RESET, d_pc4=PC_RESET+4, d_valid=0, d_excode=0.
- Reset release: first rising edge with reset=1 captures normally.
- Per rising edge, priority: flush > stall > load.
- Load: d_instr<=f_instr, d_pc<=f_pc, d_pc4<=f_pc4, d_valid<=1, d_excode<=0. Latency is one cycle from fetch to decode.
- Bad address: f_pc[1:0]!=0, or f_pc < PC_RESET, or f_pc >= PC_RESET+4*IM_WORDS. Load then gives d_instr<=0, d_excode<=EXC_ADEL, d_valid<=1, and d_pc/d_pc4 capture the bad address for EPC.
- Window bounds: f_pc=PC_RESET+4*IM_WORDS-4 is legal. PC_RESET+4*IM_WORDS is bad.
- Range compare uses 32-bit unsigned arithmetic. No wrap-around at 2^32; 32'hFFFF_FFFC is bad.
- Stall: every output register holds. Stall may persist any number of cycles.
- Flush: d_instr<=0, d_valid<=0, d_excode<=0. d_pc<=f_pc and d_pc4<=f_pc4 so the PC stays meaningful for the bubble.
- flush and stall together: flush wins.
- Field outputs: purely combinational slices of d_instr, so all are 0 during a bubble or reset.
- Reset mid-stall or mid-flush: reset wins, and the reset values hold until the first edge after release.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN
- Defined:
  - Adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - Each is an internal 32-bit counter that increments on every rising edge with stall=1 (resp. flush=1), including flush+stall edges for both.
  - Counters wrap from FFFF_FFFF to 0 and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds PC_RESET, the EXC_ADEL code, NOP_INSTR=32'h0, and the field bit-position constants (OP_HI/LO, RS_HI/LO, ...). These are reused by decode and the hazard unit.
- One natural sub-module, instr_field_slice: combinational 32-bit in to the field outputs, reused later by ID/EX.

Test Plan:
- Reset: hold reset=0 for 3 cycles with f_* toggling -> d_pc=0x3000, d_pc4=0x3004, d_instr=0, d_valid=0. Release, f_pc=0x3000, f_instr=0x3C010001 -> next edge d_instr=0x3C010001, d_rt=1, d_imm16=0x0001, d_valid=1.
- Stall: load 0x3004/0x00221820, then stall=1 for 4 cycles while f_pc advances -> outputs fixed at 0x3004/0x00221820 with d_rd=3. Deassert -> next f value captured.
- Flush vs stall: stall=1 and flush=1 with f_pc=0x3010 -> d_instr=0, d_valid=0, d_pc=0x3010.
- Bad address, misaligned: f_pc=0x3002 -> d_excode=4, d_instr=0, d_pc=0x3002.
- Bad address, range: f_pc=0x3FFC gives excode 0; f_pc=0x4000 gives excode 4; f_pc=0x2FFC gives excode 4.
- Async reset: drop reset mid-cycle with no clock edge -> outputs reach reset values immediately. With IF_ID_PERF_CNT_EN, 5 stall cycles and 2 flush cycles give stall_cnt=5, flush_cnt=2, and reset clears both.

Source files
------------

// File: rtl/if_id_pipe_reg_pkg.sv
// ============================================================================
// if_id_pipe_reg_pkg : shared IF/ID constants (reset PC, exception code,
//                      NOP encoding, MIPS instruction field bit positions)
// Revision 1.0
// ============================================================================
`default_nettype none

package if_id_pipe_reg_pkg;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam int          IM_WORDS  = 1024;
  localparam logic [4:0]  EXC_ADEL  = 5'd4;
  localparam logic [4:0]  EXC_NONE  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM16_HI = 15;
  localparam int IMM16_LO = 0;
  localparam int IMM26_HI = 25;
  localparam int IMM26_LO = 0;

endpackage

`default_nettype wire

// File: rtl/if_id_pipe_reg_instr_field_slice.sv
// ============================================================================
// instr_field_slice : combinational split of a 32-bit MIPS word into fields
// Revision 1.0
// ============================================================================
`default_nettype none

module instr_field_slice (
  input  logic [31:0] instr_i,
  output logic [5:0]  op_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  shamt_o,
  output logic [5:0]  funct_o,
  output logic [15:0] imm16_o,
  output logic [25:0] imm26_o
);

  import if_id_pipe_reg_pkg::*;

  assign op_o    = instr_i[OP_HI:OP_LO];
  assign rs_o    = instr_i[RS_HI:RS_LO];
  assign rt_o    = instr_i[RT_HI:RT_LO];
  assign rd_o    = instr_i[RD_HI:RD_LO];
  assign shamt_o = instr_i[SHAMT_HI:SHAMT_LO];
  assign funct_o = instr_i[FUNCT_HI:FUNCT_LO];
  assign imm16_o = instr_i[IMM16_HI:IMM16_LO];
  assign imm26_o = instr_i[IMM26_HI:IMM26_LO];

endmodule

`default_nettype wire

// File: rtl/if_id_pipe_reg.sv
// ============================================================================
// if_id_pipe_reg : IF/ID pipeline register with stall, flush and AdEL tagging.
// Optional perf counters enabled by macro IF_ID_PERF_CNT_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module if_id_pipe_reg #(
  parameter logic [31:0] PC_RESET = if_id_pipe_reg_pkg::PC_RESET,
  parameter int          IM_WORDS = if_id_pipe_reg_pkg::IM_WORDS,
  parameter logic [4:0]  EXC_ADEL = if_id_pipe_reg_pkg::EXC_ADEL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] f_instr,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_pc4,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc4,
  output logic        d_valid,
  output logic [4:0]  d_excode,
  output logic [5:0]  d_op,
  output logic [5:0]  d_funct,
  output logic [4:0]  d_rs,
  output logic [4:0]  d_rt,
  output logic [4:0]  d_rd,
  output logic [4:0]  d_shamt,
  output logic [15:0] d_imm16,
`ifdef IF_ID_PERF_CNT_EN
  output logic [25:0] d_imm26,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`else
  output logic [25:0] d_imm26
`endif
);

  import if_id_pipe_reg_pkg::NOP_INSTR;
  import if_id_pipe_reg_pkg::EXC_NONE;

  // Upper bound kept in 33 bits so a window ending at 2^32 cannot wrap.
  localparam logic [32:0] C_PC_LIMIT = {1'b0, PC_RESET} + (33'(IM_WORDS) << 2);
  localparam logic [31:0] C_PC4_RESET = PC_RESET + 32'd4;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] pc4_q,   pc4_d;
  logic        valid_q, valid_d;
  logic [4:0]  excode_q, excode_d;
  logic        w_bad_addr;

  assign w_bad_addr = (f_pc[1:0] != 2'b00) ||
                      (f_pc < PC_RESET) ||
                      ({1'b0, f_pc} >= C_PC_LIMIT);

  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    excode_d = excode_q;
    if (flush) begin
      instr_d  = NOP_INSTR;
      pc_d     = f_pc;
      pc4_d    = f_pc4;
      valid_d  = 1'b0;
      excode_d = EXC_NONE;
    end else if (!stall) begin
      pc_d    = f_pc;
      pc4_d   = f_pc4;
      valid_d = 1'b1;
      if (w_bad_addr) begin
        instr_d  = NOP_INSTR;
        excode_d = EXC_ADEL;
      end else begin
        instr_d  = f_instr;
        excode_d = EXC_NONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q  <= NOP_INSTR;
      pc_q     <= PC_RESET;
      pc4_q    <= C_PC4_RESET;
      valid_q  <= 1'b0;
      excode_q <= EXC_NONE;
    end else begin
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      excode_q <= excode_d;
    end
  end

  assign d_instr  = instr_q;
  assign d_pc     = pc_q;
  assign d_pc4    = pc4_q;
  assign d_valid  = valid_q;
  assign d_excode = excode_q;

  instr_field_slice u_slice (
    .instr_i (instr_q),
    .op_o    (d_op),
    .rs_o    (d_rs),
    .rt_o    (d_rt),
    .rd_o    (d_rd),
    .shamt_o (d_shamt),
    .funct_o (d_funct),
    .imm16_o (d_imm16),
    .imm26_o (d_imm26)
  );

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

`default_nettype wire
